// File: rtl/bus_burst_driver_pkg.sv
// Shared types for the burst driver: FSM state encoding and bus direction constants.
package bus_burst_driver_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StDone
    } state_e;

    localparam logic ModeRead  = 1'b0;
    localparam logic ModeWrite = 1'b1;

endpackage

// File: rtl/bus_burst_driver_burst_buf.sv
// Single-port synchronous RAM: registered read (1-cycle latency), synchronous write.
module burst_buf #(
    parameter int unsigned LOCAL_ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH       = 8
) (
    input  logic                        clk,
    input  logic [LOCAL_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        wen,
    output logic [DATA_WIDTH-1:0]       rdata
);

    localparam int unsigned Depth = 2 ** LOCAL_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/bus_burst_driver.sv
// Burst bus master: moves 1..2^LEN_WIDTH-1 words between a local buffer and consecutive
// bus addresses, one single-word transaction per beat, with per-beat timeout.
module bus_burst_driver
    import bus_burst_driver_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned LOCAL_ADDR_WIDTH = 5,
    parameter int unsigned LEN_WIDTH        = 4,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        mode,
    input  logic [LEN_WIDTH-1:0]        len,
    input  logic [ADDR_WIDTH-1:0]       bus_base,
    input  logic [LOCAL_ADDR_WIDTH-1:0] local_base,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [LEN_WIDTH-1:0]        beats,
    output logic [ADDR_WIDTH-1:0]       d_addr,
    output logic [DATA_WIDTH-1:0]       d_wdata,
    output logic                        d_mode,
    output logic                        d_valid,
    input  logic                        d_ready,
    input  logic [DATA_WIDTH-1:0]       d_rdata,
    input  logic [LOCAL_ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0]       host_wdata,
    input  logic                        host_wen,
    output logic [DATA_WIDTH-1:0]       host_rdata
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e                      state_q, state_d;
    logic                        start_prev_q;
    logic                        mode_q, mode_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [LEN_WIDTH-1:0]        beats_q, beats_d, beats_inc;
    logic                        err_q, err_d;
    logic [ADDR_WIDTH-1:0]       bus_ptr_q, bus_ptr_d;
    logic [LOCAL_ADDR_WIDTH-1:0] local_ptr_q, local_ptr_d;
    logic [ADDR_WIDTH-1:0]       d_addr_q, d_addr_d;
    logic [DATA_WIDTH-1:0]       d_wdata_q, d_wdata_d;
    logic                        d_mode_q, d_mode_d;
    logic [CntW-1:0]             wait_cnt_q, wait_cnt_d;
    logic                        accept, timeout_hit, write_issue;

    logic [LOCAL_ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0]       buf_wdata, buf_rdata;
    logic                        buf_wen;

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign d_valid   = (state_q == StIssue);
    assign err       = err_q;
    assign beats     = beats_q;
    assign d_addr    = d_addr_q;
    assign d_mode    = d_mode_q;
    assign beats_inc = beats_q + LEN_WIDTH'(1);
    assign accept    = start && !start_prev_q && !busy && (len != '0);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // The fetched word only appears on the RAM output during ISSUE; it is forwarded there
    // and captured into d_wdata_q so the bus sees a stable value until the next ISSUE.
    assign write_issue = (state_q == StIssue) && (mode_q == ModeWrite);
    assign d_wdata     = write_issue ? buf_rdata : d_wdata_q;

    // Buffer belongs to the engine while busy, to the host otherwise.
    always_comb begin
        if (busy) begin
            buf_addr  = local_ptr_q;
            buf_wdata = d_rdata;
            buf_wen   = (state_q == StWait) && d_ready && (mode_q == ModeRead);
        end else begin
            buf_addr  = host_addr;
            buf_wdata = host_wdata;
            buf_wen   = host_wen;
        end
    end

    assign host_rdata = buf_rdata;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        beats_d     = beats_q;
        err_d       = err_q;
        bus_ptr_d   = bus_ptr_q;
        local_ptr_d = local_ptr_q;
        wait_cnt_d  = wait_cnt_q;
        d_addr_d    = d_addr_q;
        d_mode_d    = d_mode_q;
        d_wdata_d   = d_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d      = mode;
                    len_d       = len;
                    bus_ptr_d   = bus_base;
                    local_ptr_d = local_base;
                    err_d       = 1'b0;
                    beats_d     = '0;
                    state_d     = (mode == ModeWrite) ? StFetch : StIssue;
                end
            end
            StFetch: state_d = StIssue;
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (d_ready) begin
                    beats_d = beats_inc;
                    if (beats_inc == len_q) begin
                        state_d = StDone;
                    end else begin
                        bus_ptr_d   = bus_ptr_q + ADDR_WIDTH'(1);
                        local_ptr_d = local_ptr_q + LOCAL_ADDR_WIDTH'(1);
                        state_d     = (mode_q == ModeWrite) ? StFetch : StIssue;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Bus-facing address/direction are loaded on entry to ISSUE and held after.
        if (state_d == StIssue && state_q != StIssue) begin
            d_addr_d = bus_ptr_d;
            d_mode_d = mode_d;
        end
        if (write_issue) begin
            d_wdata_d = buf_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            start_prev_q <= 1'b1;
            mode_q       <= ModeRead;
            len_q        <= '0;
            beats_q      <= '0;
            err_q        <= 1'b0;
            bus_ptr_q    <= '0;
            local_ptr_q  <= '0;
            wait_cnt_q   <= '0;
            d_addr_q     <= '0;
            d_mode_q     <= 1'b0;
            d_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            mode_q       <= mode_d;
            len_q        <= len_d;
            beats_q      <= beats_d;
            err_q        <= err_d;
            bus_ptr_q    <= bus_ptr_d;
            local_ptr_q  <= local_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            d_addr_q     <= d_addr_d;
            d_mode_q     <= d_mode_d;
            d_wdata_q    <= d_wdata_d;
        end
    end

    burst_buf #(
        .LOCAL_ADDR_WIDTH(LOCAL_ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH)
    ) u_buf (
        .clk  (clk),
        .addr (buf_addr),
        .wdata(buf_wdata),
        .wen  (buf_wen),
        .rdata(buf_rdata)
    );

endmodule

// File: tb/tb_bus_burst_driver.sv
// Directed self-checking bench for bus_burst_driver (TIMEOUT_CYCLES = 4).
module tb_bus_burst_driver;

    logic        clk = 1'b0;
    logic        rst, start, mode, busy, done, err, d_mode, d_valid, d_ready, host_wen;
    logic [3:0]  len, beats;
    logic [15:0] bus_base, d_addr;
    logic [4:0]  local_base, host_addr;
    logic [7:0]  d_wdata, d_rdata, host_wdata, host_rdata;

    int checks = 0;
    int errors = 0;

    logic [15:0] rec_addr [8];
    logic [7:0]  rec_wdata [8];
    logic        rec_mode [8];
    int          val_cyc [8];
    logic [7:0]  resp [8];
    int          nvalid, ndone, done_cyc;
    logic        busy_n1, err_n1;

    always #5 clk = ~clk;

    bus_burst_driver #(
        .ADDR_WIDTH      (16),
        .DATA_WIDTH      (8),
        .LOCAL_ADDR_WIDTH(5),
        .LEN_WIDTH       (4),
        .TIMEOUT_CYCLES  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .len       (len),
        .bus_base  (bus_base),
        .local_base(local_base),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .beats     (beats),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_mode    (d_mode),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_wen  (host_wen),
        .host_rdata(host_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] v);
        host_addr  = a;
        host_wdata = v;
        host_wen   = 1'b1;
        tick();
        host_wen   = 1'b0;
    endtask

    task automatic host_read(input logic [4:0] a, output logic [7:0] v);
        host_addr = a;
        tick();
        v = host_rdata;
    endtask

    // Drives one burst and acts as the bus slave; dly = WAIT cycles until d_ready (0 = never).
    // Cycle n = 1 is the cycle after the start edge.
    task automatic run_burst(input logic m, input logic [3:0] l, input logic [15:0] bb,
                             input logic [4:0] lb, input int dly, input bit poke,
                             input bit retrig, input int budget);
        int delay = 0;
        int beat  = 0;
        nvalid = 0; ndone = 0; done_cyc = -1;
        mode = m; len = l; bus_base = bb; local_base = lb; start = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            start   = retrig && (n == 3);
            d_ready = 1'b0;
            if (n == 1) begin
                busy_n1 = busy;
                err_n1  = err;
            end
            if (delay > 0) begin
                delay--;
                if (delay == 0) begin
                    d_ready = 1'b1;
                    d_rdata = resp[beat % 8];
                    beat++;
                end
            end
            if (d_valid) begin
                if (nvalid < 8) begin
                    rec_addr[nvalid]  = d_addr;
                    rec_wdata[nvalid] = d_wdata;
                    rec_mode[nvalid]  = d_mode;
                    val_cyc[nvalid]   = n;
                end
                nvalid++;
                if (dly > 0) delay = dly;
            end
            if (done) begin
                ndone++;
                done_cyc = n;
            end
            host_wen   = poke && busy;
            host_addr  = (n % 2 == 1) ? 5'd10 : 5'd11;
            host_wdata = 8'hEE;
        end
        start = 1'b0; d_ready = 1'b0; host_wen = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1; start = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (beats !== 4'd0) begin errors++; $display("FAIL rst_beats got %h exp 0", beats); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_dvalid got %b exp 0", d_valid); end
        checks++; if (d_addr !== 16'h0) begin errors++; $display("FAIL rst_daddr got %h exp 0", d_addr); end
        checks++; if (d_wdata !== 8'h0) begin errors++; $display("FAIL rst_dwdata got %h exp 0", d_wdata); end
        checks++; if (d_mode !== 1'b0) begin errors++; $display("FAIL rst_dmode got %b exp 0", d_mode); end
        // start held high across reset release must not launch a burst
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy !== 1'b0 || d_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL held_start got busy seen %b exp 0", bad); end
        start = 1'b0;
        tick();
    endtask

    task automatic test_write_burst();
        logic [15:0] ea;
        int ec;
        for (int i = 0; i < 4; i++) host_write(5'(2 + i), 8'hA0 + 8'(i));
        tick();
        run_burst(1'b1, 4'd4, 16'h1001, 5'd2, 2, 1'b0, 1'b0, 22);
        checks++; if (busy_n1 !== 1'b1) begin errors++; $display("FAIL wr_busy_t1 got %b exp 1", busy_n1); end
        checks++; if (nvalid !== 4) begin errors++; $display("FAIL wr_nvalid got %0d exp 4", nvalid); end
        for (int i = 0; i < 4; i++) begin
            ea = 16'h1001 + 16'(i);
            ec = 2 + 4 * i;
            checks++; if (val_cyc[i] !== ec) begin errors++; $display("FAIL wr_vcyc[%0d] got %0d exp %0d", i, val_cyc[i], ec); end
            checks++; if (rec_addr[i] !== ea) begin errors++; $display("FAIL wr_addr[%0d] got %h exp %h", i, rec_addr[i], ea); end
            checks++; if (rec_wdata[i] !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL wr_data[%0d] got %h exp %h", i, rec_wdata[i], 8'hA0 + 8'(i)); end
            checks++; if (rec_mode[i] !== 1'b1) begin errors++; $display("FAIL wr_mode[%0d] got %b exp 1", i, rec_mode[i]); end
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL wr_ndone got %0d exp 1", ndone); end
        checks++; if (done_cyc !== 17) begin errors++; $display("FAIL wr_done_cyc got %0d exp 17", done_cyc); end
        checks++; if (beats !== 4'd4) begin errors++; $display("FAIL wr_beats got %0d exp 4", beats); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b exp 0", busy); end
        checks++; if (d_addr !== 16'h1004 || d_wdata !== 8'hA3) begin errors++; $display("FAIL wr_hold got %h/%h exp 1004/a3", d_addr, d_wdata); end
    endtask

    task automatic test_read_burst();
        logic [7:0] v;
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
        run_burst(1'b0, 4'd3, 16'h2000, 5'd30, 2, 1'b0, 1'b0, 14);
        checks++; if (nvalid !== 3) begin errors++; $display("FAIL rd_nvalid got %0d exp 3", nvalid); end
        checks++; if (val_cyc[0] !== 1 || val_cyc[2] !== 7) begin errors++; $display("FAIL rd_vcyc got %0d,%0d exp 1,7", val_cyc[0], val_cyc[2]); end
        checks++; if (rec_addr[2] !== 16'h2002 || rec_mode[0] !== 1'b0) begin errors++; $display("FAIL rd_addr got %h/%b exp 2002/0", rec_addr[2], rec_mode[0]); end
        checks++; if (done_cyc !== 10 || ndone !== 1) begin errors++; $display("FAIL rd_done got cyc %0d n %0d exp 10,1", done_cyc, ndone); end
        checks++; if (beats !== 4'd3) begin errors++; $display("FAIL rd_beats got %0d exp 3", beats); end
        host_read(5'd30, v);
        checks++; if (v !== 8'h11) begin errors++; $display("FAIL rd_buf30 got %h exp 11", v); end
        host_read(5'd31, v);
        checks++; if (v !== 8'h22) begin errors++; $display("FAIL rd_buf31 got %h exp 22", v); end
        host_read(5'd0, v);
        checks++; if (v !== 8'h33) begin errors++; $display("FAIL rd_buf0 got %h exp 33", v); end
    endtask

    task automatic test_host_vs_engine();
        logic [7:0] v;
        host_write(5'd10, 8'h00);
        host_write(5'd11, 8'h00);
        tick();
        resp[0] = 8'h5A; resp[1] = 8'h5B;
        run_burst(1'b0, 4'd2, 16'h3000, 5'd10, 2, 1'b1, 1'b0, 12);
        checks++; if (ndone !== 1) begin errors++; $display("FAIL hv_ndone got %0d exp 1", ndone); end
        host_read(5'd10, v);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL hv_buf10 got %h exp 5a", v); end
        host_read(5'd11, v);
        checks++; if (v !== 8'h5B) begin errors++; $display("FAIL hv_buf11 got %h exp 5b", v); end
    endtask

    task automatic test_timeout();
        run_burst(1'b0, 4'd2, 16'h4000, 5'd5, 0, 1'b0, 1'b0, 12);
        checks++; if (nvalid !== 1) begin errors++; $display("FAIL to_nvalid got %0d exp 1", nvalid); end
        checks++; if (done_cyc !== 6 || ndone !== 1) begin errors++; $display("FAIL to_done got cyc %0d n %0d exp 6,1", done_cyc, ndone); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err got %b exp 1", err); end
        checks++; if (beats !== 4'd0) begin errors++; $display("FAIL to_beats got %0d exp 0", beats); end
    endtask

    task automatic test_start_filtering();
        logic bad = 1'b0;
        mode = 1'b0; len = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL len0 got activity %b exp 0", bad); end
        resp[0] = 8'h71; resp[1] = 8'h72;
        run_burst(1'b0, 4'd2, 16'h3100, 5'd12, 2, 1'b0, 1'b1, 14);
        checks++; if (err_n1 !== 1'b0) begin errors++; $display("FAIL sf_err_clear got %b exp 0", err_n1); end
        checks++; if (nvalid !== 2 || ndone !== 1) begin errors++; $display("FAIL sf_retrig got v %0d d %0d exp 2,1", nvalid, ndone); end
        checks++; if (beats !== 4'd2 || busy !== 1'b0) begin errors++; $display("FAIL sf_end got beats %0d busy %b exp 2,0", beats, busy); end
    endtask

    task automatic test_mid_reset();
        int nd = 0;
        mode = 1'b0; len = 4'd3; bus_base = 16'h5000; local_base = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL mr_issue got %b exp 1", d_valid); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL mr_state got busy %b valid %b exp 0,0", busy, d_valid); end
        checks++; if (done !== 1'b0 || d_addr !== 16'h0) begin errors++; $display("FAIL mr_regs got done %b addr %h exp 0,0", done, d_addr); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL mr_nodone got %0d exp 0", nd); end
        run_burst(1'b1, 4'd2, 16'h6000, 5'd2, 1, 1'b0, 1'b0, 14);
        checks++; if (nvalid !== 2 || ndone !== 1 || done_cyc !== 7) begin errors++; $display("FAIL mr_new got v %0d d %0d c %0d exp 2,1,7", nvalid, ndone, done_cyc); end
        checks++; if (rec_addr[1] !== 16'h6001 || rec_wdata[1] !== 8'hA1) begin errors++; $display("FAIL mr_new_data got %h/%h exp 6001/a1", rec_addr[1], rec_wdata[1]); end
        checks++; if (beats !== 4'd2 || err !== 1'b0) begin errors++; $display("FAIL mr_new_end got beats %0d err %b exp 2,0", beats, err); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0; bus_base = '0; local_base = '0;
        d_ready = 1'b0; d_rdata = '0; host_addr = '0; host_wdata = '0; host_wen = 1'b0;
        for (int i = 0; i < 8; i++) resp[i] = '0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_host_vs_engine();
        test_timeout();
        test_start_filtering();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
